// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared register map, CTRL bit positions and 7-segment glyph helper
package mmio_pkg;

    localparam int REG_LEDS    = 0;
    localparam int REG_SEG7    = 1;
    localparam int REG_SWS     = 2;
    localparam int REG_SW_EDGE = 3;
    localparam int REG_TIMER   = 4;
    localparam int REG_CMP     = 5;
    localparam int REG_CTRL    = 6;
    localparam int REG_STAT    = 7;

    localparam int CTRL_TEN   = 0;
    localparam int CTRL_ARL   = 1;
    localparam int CTRL_TIE   = 2;
    localparam int CTRL_SIE   = 3;
    localparam int CTRL_BLANK = 8;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    // Active-low glyph, bit 0 = segment a ... bit 6 = segment g
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - switch synchroniser, shared sample tick, debounced state and edge pulse
module sw_debounce #(
    parameter int N_SW       = 18,
    parameter int DEB_CYCLES = 500000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N_SW-1:0] sw_i,
    output logic [N_SW-1:0] deb_o,
    output logic [N_SW-1:0] edge_o
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [N_SW-1:0] sync1_q, sync2_q, samp_q, samp_d, deb_q, deb_d, agree;
    logic [CW-1:0]   tick_q, tick_d;
    logic            tick;

    always_comb begin
        tick   = (tick_q == CW'(DEB_CYCLES - 1));
        tick_d = tick ? '0 : tick_q + CW'(1);
        agree  = ~(sync2_q ^ samp_q);
        samp_d = samp_q;
        deb_d  = deb_q;
        if (tick) begin
            samp_d = sync2_q;
            // only two matching consecutive samples may move the debounced value
            deb_d  = (agree & sync2_q) | (~agree & deb_q);
        end
    end

    assign deb_o  = deb_q;
    assign edge_o = deb_d ^ deb_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            deb_q   <= '0;
            tick_q  <= '0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            samp_q  <= samp_d;
            deb_q   <= deb_d;
            tick_q  <= tick_d;
        end
    end

endmodule

// File: rtl/mmio_periph.sv
// rtl/mmio_periph.sv - I/O page: LEDs, 7-segment, debounced switches, compare timer and irq
module mmio_periph
    import mmio_pkg::*;
#(
    parameter int IO_PAGE_BIT = 22,
    parameter int N_LEDS      = 18,
    parameter int N_SW        = 18,
    parameter int N_DIGITS    = 6,
    parameter int DEB_CYCLES  = 500000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wmask,
    output logic [31:0]           mem_rdata,
    input  logic [N_SW-1:0]       sw,
    output logic [N_LEDS-1:0]     leds,
    output logic [7*N_DIGITS-1:0] hex,
    output logic                  irq
);
    logic [N_LEDS-1:0]     leds_q, leds_d;
    logic [4*N_DIGITS-1:0] seg_q, seg_d;
    logic [N_SW-1:0]       edge_q, edge_d, sw_deb, sw_edge, edge_clr;
    logic [31:0]           cnt_q, cnt_d, cmp_q, cmp_d;
    logic [3:0]            ctrl_q, ctrl_d;
    logic [N_DIGITS-1:0]   blank_q, blank_d;
    logic                  stat_q, stat_d, irq_q, irq_d;
    logic [7:0]            word, sel1h, we;
    logic [31:0]           bm;
    logic [31:0]           regv [8];
    logic                  match;
    logic                  unused_addr;

    sw_debounce #(.N_SW(N_SW), .DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk    (clk),
        .resetn (resetn),
        .sw_i   (sw),
        .deb_o  (sw_deb),
        .edge_o (sw_edge)
    );

    // isolate the lowest set word-address bit so overlapping selects resolve deterministically
    assign word        = mem_addr[9:2];
    assign sel1h       = mem_addr[IO_PAGE_BIT] ? (word & (~word + 8'd1)) : 8'd0;
    assign we          = (|mem_wmask) ? sel1h : 8'd0;
    assign bm          = {{8{mem_wmask[3]}}, {8{mem_wmask[2]}}, {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};
    assign unused_addr = ^{mem_addr[31:10], mem_addr[1:0]};
    assign match       = ctrl_q[CTRL_TEN] && (cnt_q == cmp_q);

    always_comb begin
        regv = '{default: 32'd0};
        regv[REG_LEDS]    = 32'(leds_q);
        regv[REG_SEG7]    = 32'(seg_q);
        regv[REG_SWS]     = 32'(sw_deb);
        regv[REG_SW_EDGE] = 32'(edge_q);
        regv[REG_TIMER]   = cnt_q;
        regv[REG_CMP]     = cmp_q;
        regv[REG_CTRL][3:0] = ctrl_q;
        regv[REG_CTRL][CTRL_BLANK +: N_DIGITS] = blank_q;
        regv[REG_STAT][0] = stat_q;
        mem_rdata = 32'd0;
        for (int k = 0; k < 8; k++) begin
            mem_rdata = mem_rdata | (regv[k] & {32{sel1h[k]}});
        end
    end

    always_comb begin
        leds_d  = leds_q;
        seg_d   = seg_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        blank_d = blank_q;
        cnt_d   = cnt_q;
        if (we[REG_LEDS])
            leds_d = (leds_q & ~bm[N_LEDS-1:0]) | (mem_wdata[N_LEDS-1:0] & bm[N_LEDS-1:0]);
        if (we[REG_SEG7])
            seg_d = (seg_q & ~bm[4*N_DIGITS-1:0]) | (mem_wdata[4*N_DIGITS-1:0] & bm[4*N_DIGITS-1:0]);
        if (we[REG_CMP])
            cmp_d = (cmp_q & ~bm) | (mem_wdata & bm);
        if (we[REG_CTRL]) begin
            ctrl_d  = (ctrl_q & ~bm[3:0]) | (mem_wdata[3:0] & bm[3:0]);
            blank_d = (blank_q & ~bm[CTRL_BLANK +: N_DIGITS])
                    | (mem_wdata[CTRL_BLANK +: N_DIGITS] & bm[CTRL_BLANK +: N_DIGITS]);
        end
        // a bus write beats both reload and increment
        if (we[REG_TIMER])
            cnt_d = (cnt_q & ~bm) | (mem_wdata & bm);
        else if (ctrl_q[CTRL_TEN])
            cnt_d = (match && ctrl_q[CTRL_ARL]) ? 32'd0 : cnt_q + 32'd1;
        edge_clr = we[REG_SW_EDGE] ? (mem_wdata[N_SW-1:0] & bm[N_SW-1:0]) : '0;
        edge_d   = sw_edge | (edge_q & ~edge_clr);
        stat_d   = match | (stat_q & ~(we[REG_STAT] & mem_wdata[0] & bm[0]));
        irq_d    = (ctrl_q[CTRL_TIE] & stat_q) | (ctrl_q[CTRL_SIE] & (|edge_q));
    end

    always_comb begin
        hex = '0;
        for (int d = 0; d < N_DIGITS; d++) begin
            hex[7*d +: 7] = blank_q[d] ? 7'h7F : hex7(seg_q[4*d +: 4]);
        end
    end

    assign leds = leds_q;
    assign irq  = irq_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            leds_q  <= '0;
            seg_q   <= '0;
            edge_q  <= '0;
            cnt_q   <= '0;
            cmp_q   <= CMP_RESET;
            ctrl_q  <= '0;
            blank_q <= '0;
            stat_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            leds_q  <= leds_d;
            seg_q   <= seg_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            blank_q <= blank_d;
            stat_q  <= stat_d;
            irq_q   <= irq_d;
        end
    end

endmodule

// File: tb/tb_mmio_periph.sv
// tb/tb_mmio_periph.sv - self-checking bench for mmio_periph with DEB_CYCLES=4
module tb_mmio_periph;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [17:0] sw;
    logic [17:0] leds;
    logic [41:0] hex;
    logic        irq;

    mmio_periph #(
        .IO_PAGE_BIT(22), .N_LEDS(18), .N_SW(18), .N_DIGITS(6), .DEB_CYCLES(4)
    ) dut (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .sw(sw), .leds(leds),
        .hex(hex), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] exp_rst [8];
    logic [31:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;
    logic        ok;
    logic [31:0] m_cnt;
    logic        m_stat, m_irq, m_irq_n, m_match;
    logic [31:0] ma;

    localparam logic [31:0] IO = 32'h0040_0000;

    function automatic logic [31:0] ra(input int i);
        return IO | (32'd4 << i);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        tick();
        mem_wmask = 4'h0;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        mem_addr  = a;
        mem_wmask = 4'h0;
        sb_q.push_back(e);
        #1;
        chk(nm, 64'(mem_rdata), 64'(sb_q.pop_front()));
    endtask

    initial begin
        vecs[0]  = '{ra(0), 32'hFFFF_FFFF, 4'b0011, ra(0), 32'h0000_FFFF};
        vecs[1]  = '{ra(0), 32'hFFFF_FFFF, 4'b1111, ra(0), 32'h0003_FFFF};
        vecs[2]  = '{ra(1), 32'h0012_3456, 4'b1111, ra(1), 32'h0012_3456};
        vecs[3]  = '{ra(6), 32'hFFFF_FFF0, 4'b1111, ra(6), 32'h0000_3F00};
        vecs[4]  = '{ra(6), 32'h0000_0100, 4'b1111, ra(6), 32'h0000_0100};
        vecs[5]  = '{ra(5), 32'h1234_5678, 4'b0100, ra(5), 32'hFF34_FFFF};
        vecs[6]  = '{ra(2), 32'hFFFF_FFFF, 4'b1111, ra(2), 32'h0000_0000};
        vecs[7]  = '{ra(7), 32'hFFFF_FFFF, 4'b1111, ra(7), 32'h0000_0000};
        vecs[8]  = '{32'h0000_0004, 32'h0, 4'b1111, ra(0), 32'h0003_FFFF};
        vecs[9]  = '{32'h0000_0004, 32'h0, 4'b1111, 32'h0000_0004, 32'h0};
        vecs[10] = '{IO, 32'h0, 4'b1111, ra(0), 32'h0003_FFFF};
        vecs[11] = '{IO, 32'h0, 4'b1111, IO, 32'h0};
        vecs[12] = '{ra(5), 32'h0000_0005, 4'b1111, ra(5), 32'h0000_0005};
        exp_rst  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};

        resetn = 1'b0; sw = '0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
        repeat (3) tick();
        chk("rst_leds", 64'(leds), 64'd0);
        chk("rst_hex", 64'(hex), 64'({6{7'h40}}));
        chk("rst_irq", 64'(irq), 64'd0);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_reg%0d", i), ra(i), exp_rst[i]);

        for (int i = 0; i < 13; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata, vecs[i].wmask);
            rd_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end
        chk("leds_out", 64'(leds), 64'h3FFFF);
        chk("hex_glyphs", 64'(hex), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h7F}));

        // switch 3 rises with a one-cycle bounce
        sw[3] = 1'b1; tick(); sw[3] = 1'b0; tick(); sw[3] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            mem_addr = ra(2);
            #1;
            if (mem_rdata[3]) ok = 1'b1;
        end
        chk("sws_rise_timely", 64'(ok), 64'd1);
        rd_chk("sws_after_rise", ra(2), 32'h8);
        rd_chk("edge_after_rise", ra(3), 32'h8);
        chk("irq_no_sie", 64'(irq), 64'd0);

        // W1C on SW_EDGE issued every cycle until the falling edge qualifies: set must win
        wr(ra(3), 32'h8, 4'hF);
        rd_chk("edge_cleared", ra(3), 32'h0);
        sw[3] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            mem_addr = ra(3); mem_wdata = 32'h8; mem_wmask = 4'hF;
            tick();
            mem_wmask = 4'h0;
            mem_addr = ra(2);
            #1;
            if (!mem_rdata[3]) ok = 1'b1;
        end
        chk("sws_fall_timely", 64'(ok), 64'd1);
        rd_chk("w1c_vs_set", ra(3), 32'h8);

        wr(ra(6), 32'h108, 4'hF);
        chk("irq_sie_latency", 64'(irq), 64'd0);
        tick();
        chk("irq_sie", 64'(irq), 64'd1);
        wr(ra(6), 32'h100, 4'hF);
        tick();
        chk("irq_sie_off", 64'(irq), 64'd0);

        // compare timer with auto-reload, checked against a cycle model
        wr(ra(4), 32'h0, 4'hF);
        wr(ra(6), 32'h7, 4'hF);
        m_cnt = 32'd0; m_stat = 1'b0; m_irq = 1'b0;
        for (int i = 0; i < 14; i++) begin
            rd_chk($sformatf("tmr_cnt%0d", i), ra(4), m_cnt);
            rd_chk($sformatf("tmr_stat%0d", i), ra(7), {31'd0, m_stat});
            chk($sformatf("tmr_irq%0d", i), 64'(irq), 64'(m_irq));
            m_irq_n = m_stat;
            m_match = (m_cnt == 32'd5);
            m_stat  = m_stat | m_match;
            m_cnt   = m_match ? 32'd0 : m_cnt + 32'd1;
            m_irq   = m_irq_n;
            tick();
        end
        wr(ra(6), 32'h4, 4'hF);
        wr(ra(7), 32'h1, 4'hF);
        chk("irq_hold_after_w1c", 64'(irq), 64'd1);
        tick();
        chk("irq_drop_after_w1c", 64'(irq), 64'd0);
        rd_chk("stat_cleared", ra(7), 32'h0);

        // TIMER write in the cycle of a match: flag sets, written value loads
        wr(ra(6), 32'h1, 4'hF);
        wr(ra(4), 32'h5, 4'hF);
        wr(ra(4), 32'h100, 4'hF);
        rd_chk("wr_vs_match_cnt", ra(4), 32'h100);
        rd_chk("wr_vs_match_stat", ra(7), 32'h1);

        wr(ra(7), 32'h1, 4'hF);
        wr(ra(4), 32'hFFFF_FFFE, 4'hF);
        rd_chk("wrap0", ra(4), 32'hFFFF_FFFE);
        tick();
        rd_chk("wrap1", ra(4), 32'hFFFF_FFFF);
        tick();
        rd_chk("wrap2", ra(4), 32'h0);
        tick();
        rd_chk("wrap3", ra(4), 32'h1);

        // word bits 3 and 5 both set: lowest (SW_EDGE) wins
        ma = IO | (32'd1 << 5) | (32'd1 << 7);
        rd_chk("multi_rd", ma, 32'h8);
        wr(ma, 32'hFFFF_FFFF, 4'hF);
        rd_chk("multi_wr_edge", ra(3), 32'h0);
        rd_chk("multi_wr_cmp", ra(5), 32'h5);

        // reset in the middle of operation
        resetn = 1'b0;
        tick();
        chk("mid_rst_leds", 64'(leds), 64'd0);
        chk("mid_rst_hex", 64'(hex), 64'({6{7'h40}}));
        chk("mid_rst_irq", 64'(irq), 64'd0);
        rd_chk("mid_rst_timer", ra(4), 32'h0);
        rd_chk("mid_rst_cmp", ra(5), 32'hFFFF_FFFF);
        rd_chk("mid_rst_ctrl", ra(6), 32'h0);
        resetn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_periph.md
# mmio_periph

Parametrised memory-mapped I/O page for the RISC-V SoC: LED register, N-digit 7-segment register with per-digit blanking, debounced switches with sticky edge capture, and a 32-bit compare timer with a combined interrupt line. It sits on the processor data bus beside the RAM and owns every I/O-page register. Reads are combinational, so the processor sees data in the same cycle as the address.

## Interface
- `IO_PAGE_BIT`, default 22: address bit that selects the I/O page.
- `N_LEDS`, default 18: LED count; must be 32 or less.
- `N_SW`, default 18: switch count; must be 32 or less.
- `N_DIGITS`, default 6: 7-segment digit count; must be 8 or less.
- `DEB_CYCLES`, default 500000: debounce sample period in clk cycles (10 ms at 50 MHz); must be 2 or more.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `mem_addr`  in  32  byte address from the processor.
- `mem_wdata`  in  32  write data.
- `mem_wmask`  in  4  byte write enables; any bit set means a write.
- `mem_rdata`  out  32  read data for I/O addresses; 0 when `mem_addr[IO_PAGE_BIT]` is 0.
- `sw`  in  N_SW  raw asynchronous switches.
- `leds`  out  N_LEDS  LED drive.
- `hex`  out  7*N_DIGITS  active-low segments; digit d occupies `[7d+6:7d]`.
- `irq`  out  1  level interrupt.

## Operation
- Access decode: the block is selected when `mem_addr[IO_PAGE_BIT]` is 1.
- Register select uses one-hot word address `mem_addr[9:2]`. The lowest set bit wins for both read and write; if no bit is set, reads return 0 and writes are ignored.
- Writes honour `mem_wmask` per byte. Bits above a register's width read as 0.
- Register map (index = word-address bit):
  - 0 LEDS: RW, low N_LEDS bits.
  - 1 SEG7: RW, 4-bit hex value per digit; digit d is `[4d+3:4d]`.
  - 2 SWS: R, debounced switch state.
  - 3 SW_EDGE: R/W1C; bit i is set on any edge of debounced switch i.
  - 4 TIMER: RW; reads the live count, a write loads the count.
  - 5 TIMER_CMP: RW.
  - 6 CTRL: RW.
    - [0] timer enable.
    - [1] auto-reload.
    - [2] timer irq enable.
    - [3] switch-edge irq enable.
    - [8+d] blank digit d.
  - 7 STAT: R/W1C; [0] timer match.
- Reset values: every register is 0 except TIMER_CMP, which resets to 0xFFFFFFFF.
- Outputs during reset: `leds` = 0, `hex` shows "0" on every digit (7'h40), `irq` = 0.
- Debounce path, per switch:
  - Two-flop synchroniser.
  - A shared sample tick every DEB_CYCLES cycles.
  - The debounced bit updates only when two consecutive samples agree and differ from the current debounced value.
- SW_EDGE sets in the cycle the debounced bit changes.
- Timer:
  - When enabled, the count increments by 1 per cycle and wraps from 0xFFFFFFFF to 0.
  - When count == TIMER_CMP and the timer is enabled, STAT[0] is set. The next count is 0 if auto-reload is on, otherwise count+1.
- `irq` = (CTRL[2] & STAT[0]) | (CTRL[3] & |SW_EDGE), registered.
- Segment output per digit: 7'h7F when blanked, otherwise the standard hex glyph, active-low.

## Timing
- Register writes take effect at the rising clk edge of the write cycle. `leds` and `hex` follow that edge directly; `irq` follows one cycle later.
- `mem_rdata` is combinational from registers and address, with no wait states. Reads have no side effects.
- Switch latency: 2 cycles of synchronisation, plus 1–2 sample periods of debounce.
- Simultaneous events:
  - W1C and a set event in the same cycle: the set wins and the bit stays 1.
  - Bits written 0 under W1C are unchanged.
  - TIMER write and compare match in the same cycle: the match is evaluated on the pre-write count, STAT[0] sets, and the written value is loaded (the write beats the reload/increment).
  - A TIMER_CMP write takes effect for comparison starting the next cycle.
- Reset asserted mid-operation returns all state, including the debounce counters and synchroniser flops, to reset values on the next edge. Synchroniser flops reset to 0.
- The debounce tick counter runs continuously, independent of bus activity.

## Structure
- Package `mmio_pkg` holds:
  - Register index localparams (LEDS … STAT).
  - CTRL bit positions.
  - TIMER_CMP reset constant.
  - Function `hex7(input [3:0]) -> [6:0]`, active-low glyph.
- Sub-module `sw_debounce` (parameters N_SW, DEB_CYCLES) contains the synchroniser, sample tick, debounced register and edge pulse output. Sticky SW_EDGE stays in the top block.
- The top block holds the decode, registers, timer, read mux and irq.

## Test plan
All scenarios use DEB_CYCLES=4 and IO_PAGE_BIT=22.
- Reset, then read every register: CMP reads 0xFFFFFFFF, all others read 0, `hex` shows 7'h40 on every digit, `irq` = 0.
- Write LEDS = 0xFFFFFFFF with wmask 4'b0011: LEDS reads 0x0000FFFF. Write SEG7 = 0x123456, then CTRL = 0x0100: digit 0 is 7'h7F, digit 1 is the "5" glyph.
- Raise `sw[3]` with 2 cycles of bounce: SWS[3] = 1 within 2+2·4 cycles, SW_EDGE = 0x8. Write SW_EDGE = 0x8 in the same cycle a new edge on `sw[3]` is qualified: the bit stays 1.
- Set CMP = 5 and CTRL = 0x7 (enable, auto-reload, irq enable): STAT[0] sets on the cycle after count reaches 5, `irq` is 1 one cycle later, and the count reloads to 0. Write STAT = 1: `irq` drops.
- Load TIMER = 0xFFFFFFFE with CTRL = 0x1: the count wraps to 0 after 2 cycles, with no auto-reload.
- Address with bits 3 and 5 both set: the read returns SW_EDGE, a write affects SW_EDGE only. An address with bit 22 = 0 gives `mem_rdata` = 0 and no register changes.
